// File: rtl/mul_seq.sv
// Iterative RV32M multiplier: shift-add over operand magnitudes, sign fix-up in FIN.
// Optional early termination on zero operands / exhausted multiplier: MUL_SEQ_EARLY_OUT_EN.
module mul_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      funct,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] prod
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N);
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state, state_n;
    logic [1:0]      funct_q;
    logic [PW-1:0]   mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;

    logic            accept, fin_ok, busy_n, last;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] mag1, mag2;
    logic            zero_op, rest_zero;

    // Only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
    assign rs1_neg = (funct == 2'b01 || funct == 2'b10) && rs1[XLEN-1];
    assign rs2_neg = (funct == 2'b01) && rs2[XLEN-1];
    assign mag1    = rs1_neg ? -rs1 : rs1;
    assign mag2    = rs2_neg ? -rs2 : rs2;
    assign last    = (cnt_q == CW'(N - 1));

`ifdef MUL_SEQ_EARLY_OUT_EN
    assign zero_op   = (rs1 == '0) || (rs2 == '0);
    assign rest_zero = ((mplier_q >> BITS_PER_CYCLE) == '0);
`else
    assign zero_op   = 1'b0;
    assign rest_zero = 1'b0;
`endif

    // One partial product per multiplier bit retired this cycle
    logic [BITS_PER_CYCLE-1:0][PW-1:0] pp;
    logic [PW-1:0]                     pp_sum;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_pp
        assign pp[i] = mplier_q[i] ? (mcand_q << i) : '0;
    end

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            pp_sum = pp_sum + pp[i];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; KILL is deliberately ignored in IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = zero_op ? FIN : RUN;
            RUN: begin
                if (kill)                   state_n = IDLE;
                else if (last || rest_zero) state_n = FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output/control decode; BUSY covers the cycle DONE is high
    always_comb begin
        accept = (state == IDLE) && start;
        fin_ok = (state == FIN) && !kill;
        busy_n = (state_n != IDLE) || fin_ok;
    end

    logic [PW-1:0] res;
    assign res = neg_q ? -acc_q : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            prod     <= '0;
        end else begin
            busy <= busy_n;
            done <= fin_ok;
            if (accept) begin
                funct_q  <= funct;
                mcand_q  <= {{XLEN{1'b0}}, mag1};
                mplier_q <= mag2;
                neg_q    <= rs1_neg ^ rs2_neg;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state == RUN) begin
                acc_q    <= acc_q + pp_sum;
                mcand_q  <= mcand_q << BITS_PER_CYCLE;
                mplier_q <= mplier_q >> BITS_PER_CYCLE;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (fin_ok)
                prod <= (funct_q == 2'b00) ? res[XLEN-1:0] : res[PW-1:XLEN];
        end
    end
endmodule
